music_score_player: RTL and testbench

- Sequencer that reads a 12-bit music score ROM (entry format {high[3:0], med[3:0], low[3:0]}, value 1..7 = C..B, 0 = rest) one entry per beat.
- Decodes each entry into a square-wave tone for the on-board passive buzzer.
- Drives the ROM address and expects combinational ROM data on the same cycle.
- Sits between the score ROM and the buzzer pin; start/stop come from the button/control logic.

---
 rtl/music_score_player.sv | 174 +++++++++++++++++
 tb/tb_music_score_player.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/music_score_player.sv
`default_nettype none
// ============================================================================
// Module   : music_score_player
// Purpose  : Steps a 12-bit score ROM one entry per beat and plays a buzzer tone.
// Revision : 1.0
// ============================================================================
module music_score_player #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int ROM_WIDTH   = 12,
    parameter int ROM_DEPTH   = 128,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic                  buzzer,
    output logic                  playing,
    output logic                  done,
    output logic [3:0]            note_idx,
    output logic [1:0]            octave
);
    localparam int C_TONE_W = $clog2(CLK_FREQ / (2 * 262) + 1);
    localparam int C_BEAT_W = $clog2(BEAT_CYCLES);
    localparam logic [C_BEAT_W-1:0]   C_BEAT_LAST = C_BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_LAST = ADDR_WIDTH'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [C_BEAT_W-1:0]   r_beat_cnt;
    logic [C_TONE_W-1:0]   r_tone_cnt;
    logic [C_TONE_W-1:0]   r_half_prev;
    logic [C_TONE_W-1:0]   w_half;
    logic [C_TONE_W-1:0]   w_half_tab [32];
    logic [4:0]            w_tab_idx;
    logic                  w_rest;
    logic                  w_finish;

    // Table index = (octave-1)*7 + (note-1); entries 21..31 are unused zeros.
    function automatic int half_period(input int idx);
        int f;
        case (idx % 7)
            0:       f = 262;
            1:       f = 294;
            2:       f = 330;
            3:       f = 349;
            4:       f = 392;
            5:       f = 440;
            default: f = 494;
        endcase
        f = f << (idx / 7);
        return (idx < 21) ? CLK_FREQ / (2 * f) : 0;
    endfunction

    // Returns {octave, note}; first field holding 1..7 wins, high first.
    function automatic logic [5:0] decode(input logic [11:0] e);
        logic [5:0] r;
        r = '0;
        if (e[11:8] inside {[4'd1:4'd7]})
            r = {2'd3, e[11:8]};
        else if (e[7:4] inside {[4'd1:4'd7]})
            r = {2'd2, e[7:4]};
        else if (e[3:0] inside {[4'd1:4'd7]})
            r = {2'd1, e[3:0]};
        return r;
    endfunction

    generate
        for (genvar g = 0; g < 32; g++) begin : g_half
            assign w_half_tab[g] = C_TONE_W'(half_period(g));
        end
    endgenerate

    assign w_rest    = (note_idx == 4'd0);
    assign w_tab_idx = 5'(({3'd0, octave} - 5'd1) * 5'd7 + {1'b0, note_idx} - 5'd1);
    assign w_half    = w_rest ? '0 : w_half_tab[w_tab_idx];
    assign w_finish  = (r_state == S_PLAY) && (r_beat_cnt == C_BEAT_LAST) &&
                       (rom_addr == C_ADDR_LAST) && !loop_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            rom_addr   <= '0;
            playing    <= 1'b0;
            done       <= 1'b0;
            note_idx   <= 4'd0;
            octave     <= 2'd0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                r_state    <= S_IDLE;
                r_beat_cnt <= '0;
                rom_addr   <= '0;
                playing    <= 1'b0;
                note_idx   <= 4'd0;
                octave     <= 2'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        rom_addr   <= '0;
                        playing    <= 1'b0;
                        note_idx   <= 4'd0;
                        octave     <= 2'd0;
                        r_beat_cnt <= '0;
                        if (start) begin
                            r_state <= S_PLAY;
                            playing <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (r_beat_cnt == '0)
                            {octave, note_idx} <= decode(rom_data[11:0]);
                        if (r_beat_cnt == C_BEAT_LAST) begin
                            r_beat_cnt <= '0;
                            if (rom_addr != C_ADDR_LAST) begin
                                rom_addr <= rom_addr + 1'b1;
                            end else if (loop_en) begin
                                rom_addr <= '0;
                            end else begin
                                r_state  <= S_DONE;
                                rom_addr <= '0;
                                note_idx <= 4'd0;
                                octave   <= 2'd0;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        done     <= 1'b1;
                        playing  <= 1'b0;
                        rom_addr <= '0;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Phase restarts only when the pitch changes, so repeated notes stay continuous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt  <= '0;
            r_half_prev <= '0;
            buzzer      <= 1'b0;
        end else if (stop || w_finish || (r_state != S_PLAY) || w_rest) begin
            r_tone_cnt  <= '0;
            r_half_prev <= '0;
            buzzer      <= 1'b0;
        end else if (w_half != r_half_prev) begin
            r_tone_cnt  <= '0;
            r_half_prev <= w_half;
            buzzer      <= 1'b0;
        end else if (r_tone_cnt == w_half - C_TONE_W'(1)) begin
            r_tone_cnt <= '0;
            buzzer     <= ~buzzer;
        end else begin
            r_tone_cnt <= r_tone_cnt + C_TONE_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_music_score_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_music_score_player
// Purpose  : Randomized bench for music_score_player against a beat/phase model.
// Revision : 1.0
// ============================================================================
module tb_music_score_player;
    localparam int CLK_HZ = 1_000_000;
    localparam int B_S    = 16;
    localparam int B_T    = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [6:0]  addr_s, addr_t;
    logic [11:0] data_s, data_t;
    logic        buz_s, buz_t, play_s, play_t, done_s, done_t;
    logic [3:0]  note_s, note_t;
    logic [1:0]  oct_s, oct_t;
    logic [11:0] rom_s [128];
    logic [11:0] rom_t [128];

    assign data_s = rom_s[addr_s];
    assign data_t = rom_t[addr_t];

    always #5 clk = ~clk;

    music_score_player #(.CLK_FREQ(CLK_HZ), .BEAT_CYCLES(B_S), .ROM_WIDTH(12),
                         .ROM_DEPTH(128), .ADDR_WIDTH(7)) u_seq (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(addr_s), .rom_data(data_s), .buzzer(buz_s), .playing(play_s),
        .done(done_s), .note_idx(note_s), .octave(oct_s));

    music_score_player #(.CLK_FREQ(CLK_HZ), .BEAT_CYCLES(B_T), .ROM_WIDTH(12),
                         .ROM_DEPTH(128), .ADDR_WIDTH(7)) u_tone (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(addr_t), .rom_data(data_t), .buzzer(buz_t), .playing(play_t),
        .done(done_t), .note_idx(note_t), .octave(oct_t));

    int n_cmp = 0;
    int n_bad = 0;

    // Model per player: phase 0 idle, 1 playing, 2 final-beat tail, 3 done pulse.
    int ph [2];
    int n [2];
    int cur_h [2];
    int seg [2];
    int ex_note [2];
    int ex_oct [2];
    int ecount = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int beats(input int d);
        return (d == 0) ? B_S : B_T;
    endfunction

    function automatic logic [11:0] rom_at(input int d, input int a);
        return (d == 0) ? rom_s[a] : rom_t[a];
    endfunction

    function automatic void dec(input logic [11:0] e, output int nt, output int oc);
        nt = 0;
        oc = 0;
        for (int f = 2; f >= 0; f--) begin
            int v;
            v = int'((e >> (4 * f)) & 12'hF);
            if (v >= 1 && v <= 7 && nt == 0) begin
                nt = v;
                oc = f + 1;
            end
        end
    endfunction

    function automatic int half(input int nt, input int oc);
        int lo [7];
        lo = '{262, 294, 330, 349, 392, 440, 494};
        if (nt == 0) return 0;
        return CLK_HZ / (2 * (lo[nt-1] << (oc - 1)));
    endfunction

    task automatic model_edge(input int d);
        int p;
        int h;
        int nt;
        int oc;
        p = ph[d];
        h = (p == 1) ? half(ex_note[d], ex_oct[d]) : 0;
        if (!rst_n || stop) begin
            ph[d] = 0;
        end else begin
            case (p)
                1: begin
                    n[d]++;
                    if (n[d] % (128 * beats(d)) == 0 && !loop_en) ph[d] = 2;
                end
                2: ph[d] = 3;
                default: begin
                    if (start) begin
                        ph[d] = 1;
                        n[d]  = 0;
                    end else begin
                        ph[d] = 0;
                    end
                end
            endcase
        end
        if (ph[d] != 1 || p != 1 || h == 0) begin
            cur_h[d] = 0;
        end else if (h != cur_h[d]) begin
            cur_h[d] = h;
            seg[d]   = ecount;
        end
        if (ph[d] == 1 && n[d] >= 1) begin
            dec(rom_at(d, ((n[d] - 1) / beats(d)) % 128), nt, oc);
            ex_note[d] = nt;
            ex_oct[d]  = oc;
        end else begin
            ex_note[d] = 0;
            ex_oct[d]  = 0;
        end
    endtask

    task automatic check_dut(input int d, input logic [6:0] a, input logic p, input logic dn,
                             input logic bz, input logic [3:0] nt, input logic [1:0] oc);
        string s;
        int    ea;
        int    eb;
        s  = (d == 0) ? "seq" : "tone";
        ea = (ph[d] == 1) ? (n[d] / beats(d)) % 128 : 0;
        eb = (cur_h[d] != 0) ? ((ecount - seg[d]) / cur_h[d]) % 2 : 0;
        chk({s, "_addr"},    32'(a),  32'(ea));
        chk({s, "_playing"}, 32'(p),  32'(ph[d] == 1 || ph[d] == 2));
        chk({s, "_done"},    32'(dn), 32'(ph[d] == 3));
        chk({s, "_buzzer"},  32'(bz), 32'(eb));
        chk({s, "_note"},    32'(nt), 32'(ex_note[d]));
        chk({s, "_octave"},  32'(oc), 32'(ex_oct[d]));
    endtask

    task automatic tick();
        @(posedge clk);
        ecount++;
        model_edge(0);
        model_edge(1);
        #1;
        check_dut(0, addr_s, play_s, done_s, buz_s, note_s, oct_s);
        check_dut(1, addr_t, play_t, done_t, buz_t, note_t, oct_t);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom_s[i] = 12'($urandom);
            rom_t[i] = 12'($urandom);
        end
        rom_s[0] = 12'h001; rom_s[1] = 12'h001; rom_s[2] = 12'h005; rom_s[3] = 12'h005;
        rom_s[4] = 12'h006; rom_s[5] = 12'h006; rom_s[6] = 12'h005; rom_s[7] = 12'h000;
        rom_t[0] = 12'h006; rom_t[1] = 12'h600; rom_t[2] = 12'h031; rom_t[3] = 12'h000;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Full non-looping pass on the fast player; slow player holds its first entries.
        loop_en = 1'b0;
        pulse_start();
        repeat (128 * B_S + 4) tick();
        repeat (4 * B_T + 8 - (128 * B_S + 5)) tick();

        // Looping pass: wrap past address 127 without a done pulse.
        loop_en = 1'b1;
        pulse_start();
        repeat (128 * B_S + 60) tick();

        // Stop beats a simultaneous start, then a lone start restarts at 0.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) tick();
        pulse_start();
        repeat (40) tick();

        // Random control traffic.
        repeat (600) begin
            start   = ($urandom % 16) == 0;
            stop    = ($urandom % 40) == 0;
            loop_en = ($urandom % 2) == 0;
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset in the middle of playback.
        pulse_start();
        repeat (30) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_addr_s",  32'(addr_s),  0);
        chk("arst_play_s",  32'(play_s),  0);
        chk("arst_note_s",  32'(note_s),  0);
        chk("arst_oct_s",   32'(oct_s),   0);
        chk("arst_buz_t",   32'(buz_t),   0);
        chk("arst_play_t",  32'(play_t),  0);
        chk("arst_note_t",  32'(note_t),  0);
        chk("arst_done_s",  32'(done_s),  0);
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; cur_h[d] = 0; ex_note[d] = 0; ex_oct[d] = 0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        pulse_start();
        repeat (50) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
